// File: rtl/nois_system_nios2_qsys_0_ocimem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nois_system_nios2_qsys_0_ocimem_ctrl
// Brief    : JTAG debug-command decoder and Avalon-MM slave sharing one
//            single-port on-chip debug RAM; JTAG has priority over the CPU.
// Revision : 1.0
// ============================================================================
module nois_system_nios2_qsys_0_ocimem_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_chipselect,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_J_RD = 2'd1,
        ST_A_RD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_READ  = 2'd3
    } cmd_t;

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    state_t          r_state;
    logic [ADDR_W:0] r_mon_a;
    logic [31:0]     r_mon_d;
    logic            r_ready;
    logic            r_error;
    logic            r_pend_vld;
    cmd_t            r_pend_cmd;
    logic [35:2]     r_pend_pay;
    logic [31:0]     r_avs_readdata;
    logic            r_avs_oor;
    logic [31:0]     r_ram_q;
    logic [31:0]     r_mem [DEPTH];

    cmd_t            w_strobe_cmd;
    cmd_t            w_exec_cmd;
    logic            w_strobe_any;
    logic            w_strobe_lost;
    logic            w_exec_pend;
    logic            w_exec_new;
    logic            w_capture;
    logic            w_drop;
    logic [35:2]     w_exec_pay;
    logic [ADDR_W:0] w_load_addr;
    logic            w_load_rd;
    logic [ADDR_W:0] w_jaddr;
    logic            w_j_in_range;
    logic            w_j_rd_cmd;
    logic            w_j_ram_rd;
    logic            w_j_ram_wr;
    logic            w_j_range_err;
    logic            w_error_nxt;
    logic            w_avs_req;
    logic            w_avs_accept;
    logic            w_avs_rd;
    logic            w_avs_wr;
    logic            w_avs_in_range;
    logic [31:0]     w_avs_rdata;
    logic            w_ram_we;
    logic            w_ram_re;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [31:0]     w_ram_wdata;
    logic [3:0]      w_ram_be;
    logic            w_unused;

    assign w_unused = ^{jdo[37:36], jdo[1:0]};

    always_comb begin
        w_strobe_cmd = CMD_NONE;
        if (take_action_ocimem_a)
            w_strobe_cmd = CMD_LOAD;
        else if (take_action_ocimem_b)
            w_strobe_cmd = CMD_WRITE;
        else if (take_no_action_ocimem_a)
            w_strobe_cmd = CMD_READ;
    end

    assign w_strobe_any  = (w_strobe_cmd != CMD_NONE);
    assign w_strobe_lost = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
                         | (take_action_ocimem_b & take_no_action_ocimem_a);

    // A queued command always runs before any new strobe; a full slot drops new strobes.
    assign w_exec_pend = (r_state == ST_IDLE) & r_pend_vld;
    assign w_exec_new  = (r_state == ST_IDLE) & ~r_pend_vld & w_strobe_any;
    assign w_capture   = (r_state != ST_IDLE) & ~r_pend_vld & w_strobe_any;
    assign w_drop      = r_pend_vld & w_strobe_any;

    always_comb begin
        w_exec_cmd = CMD_NONE;
        if (w_exec_pend)
            w_exec_cmd = r_pend_cmd;
        else if (w_exec_new)
            w_exec_cmd = w_strobe_cmd;
    end

    assign w_exec_pay  = w_exec_pend ? r_pend_pay : jdo[35:2];
    assign w_load_addr = w_exec_pay[ADDR_W+2:2];
    assign w_load_rd   = w_exec_pay[35];

    assign w_jaddr       = (w_exec_cmd == CMD_LOAD) ? w_load_addr : r_mon_a;
    assign w_j_in_range  = (w_jaddr < c_depth);
    assign w_j_rd_cmd    = ((w_exec_cmd == CMD_LOAD) & w_load_rd) | (w_exec_cmd == CMD_READ);
    assign w_j_ram_rd    = w_j_rd_cmd & w_j_in_range;
    assign w_j_ram_wr    = (w_exec_cmd == CMD_WRITE) & w_j_in_range;
    assign w_j_range_err = (w_j_rd_cmd | (w_exec_cmd == CMD_WRITE)) & ~w_j_in_range;

    // A load clears the flag, but any error raised in the same cycle still sticks.
    assign w_error_nxt = ((w_exec_cmd == CMD_LOAD) ? 1'b0 : r_error)
                       | w_j_range_err | w_strobe_lost | w_drop;

    assign w_avs_req      = avs_chipselect & (avs_read | avs_write);
    assign w_avs_accept   = (r_state == ST_IDLE) & ~w_strobe_any & ~r_pend_vld & w_avs_req;
    assign w_avs_rd       = w_avs_accept & avs_read;
    assign w_avs_wr       = w_avs_accept & avs_write & ~avs_read;
    assign w_avs_in_range = ({1'b0, avs_address} < c_depth);
    assign w_avs_rdata    = r_avs_oor ? 32'h0 : r_ram_q;

    assign avs_waitrequest = w_avs_req & ~(w_avs_wr | ((r_state == ST_A_RD) & avs_read));

    // Read data is presented straight from the RAM register while in A_RD, then held.
    assign avs_readdata  = (r_state == ST_A_RD) ? w_avs_rdata : r_avs_readdata;
    assign MonDReg       = r_mon_d;
    assign monitor_ready = r_ready;
    assign monitor_error = r_error;

    assign w_ram_we    = w_j_ram_wr | (w_avs_wr & w_avs_in_range);
    assign w_ram_re    = w_j_ram_rd | (w_avs_rd & w_avs_in_range);
    assign w_ram_addr  = w_avs_accept ? avs_address : w_jaddr[ADDR_W-1:0];
    assign w_ram_wdata = w_j_ram_wr ? w_exec_pay[34:3] : avs_writedata;
    assign w_ram_be    = w_j_ram_wr ? 4'hF : avs_byteenable;

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_ram_be[b])
                    r_mem[w_ram_addr][8*b +: 8] <= w_ram_wdata[8*b +: 8];
            end
        end
        if (w_ram_re)
            r_ram_q <= r_mem[w_ram_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_mon_a        <= '0;
            r_mon_d        <= '0;
            r_ready        <= 1'b0;
            r_error        <= 1'b0;
            r_pend_vld     <= 1'b0;
            r_pend_cmd     <= CMD_NONE;
            r_pend_pay     <= '0;
            r_avs_readdata <= '0;
            r_avs_oor      <= 1'b0;
        end else begin
            r_error <= w_error_nxt;

            if (w_capture) begin
                r_pend_vld <= 1'b1;
                r_pend_cmd <= w_strobe_cmd;
                r_pend_pay <= jdo[35:2];
            end else if (w_exec_pend) begin
                r_pend_vld <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_exec_cmd != CMD_NONE) begin
                        r_ready <= ~w_j_ram_rd;
                        r_mon_a <= (w_exec_cmd == CMD_LOAD) ? w_load_addr : r_mon_a + 1'b1;
                    end
                    if (w_j_ram_rd) begin
                        r_state <= ST_J_RD;
                    end else if (w_avs_rd) begin
                        r_state   <= ST_A_RD;
                        r_avs_oor <= ~w_avs_in_range;
                    end
                end
                ST_J_RD: begin
                    r_mon_d <= r_ram_q;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                ST_A_RD: begin
                    r_avs_readdata <= w_avs_rdata;
                    r_state        <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nois_system_nios2_qsys_0_ocimem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_nois_system_nios2_qsys_0_ocimem_ctrl
// Brief    : Scoreboard bench with a behavioural model of the debug RAM.
// Revision : 1.0
// ============================================================================
module tb_nois_system_nios2_qsys_0_ocimem_ctrl;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 200;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [37:0]       jdo;
    logic              ta_a, ta_b, tna_a;
    logic [31:0]       MonDReg;
    logic              monitor_ready, monitor_error;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_chipselect, avs_read, avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;

    nois_system_nios2_qsys_0_ocimem_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_action_ocimem_b    (ta_b),
        .take_no_action_ocimem_a (tna_a),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .avs_address             (avs_address),
        .avs_chipselect          (avs_chipselect),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int          due;
        logic        full;
        logic [31:0] dreg;
        logic        err;
    } jexp_t;

    jexp_t       jq[$];
    logic [31:0] aq[$];
    jexp_t       e_mon;
    int          checks = 0;
    int          errors = 0;

    // Reference model: RAM image plus the architectural JTAG registers.
    logic [31:0] m_ram [256];
    int          m_mona;
    logic [31:0] m_dreg;
    logic        m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_j(input int due, input logic full);
        jq.push_back('{due, full, m_dreg, m_err});
    endtask

    task automatic m_load(input int addr, input logic rd, input logic drop, input int k);
        m_mona = addr;
        m_err  = 1'b0;
        if (rd && addr < DEPTH) begin
            m_dreg = m_ram[addr];
            push_j(k + 1, 1'b0);
        end else if (rd) begin
            m_err = 1'b1;
        end
        if (drop) m_err = 1'b1;
        push_j(rd ? k + 2 : k + 1, 1'b1);
    endtask

    task automatic m_write(input logic [31:0] data, input logic drop, input int k);
        if (m_mona < DEPTH) m_ram[m_mona] = data;
        else m_err = 1'b1;
        m_mona = (m_mona + 1) % 512;
        if (drop) m_err = 1'b1;
        push_j(k + 1, 1'b1);
    endtask

    task automatic m_read(input logic drop, input int k);
        if (m_mona < DEPTH) begin
            m_dreg = m_ram[m_mona];
            push_j(k + 1, 1'b0);
        end else begin
            m_err = 1'b1;
        end
        m_mona = (m_mona + 1) % 512;
        if (drop) m_err = 1'b1;
        push_j(k + 2, 1'b1);
    endtask

    function automatic logic [37:0] mk_load(input int addr, input logic rd);
        logic [37:0]     d;
        logic [ADDR_W:0] a;
        a = addr[ADDR_W:0];
        d = {6'($urandom()), $urandom()};
        d[ADDR_W+2:2] = a;
        d[35] = rd;
        return d;
    endfunction

    function automatic logic [37:0] mk_write(input logic [31:0] data);
        logic [37:0] d;
        d = {6'($urandom()), $urandom()};
        d[34:3] = data;
        return d;
    endfunction

    task automatic clear_j();
        ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
    endtask

    task automatic clear_a();
        avs_chipselect = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
    endtask

    // kind: 0 load, 1 write, 2 read; executed immediately from IDLE
    task automatic jtag_op(input int kind, input int addr, input logic rd, input logic [31:0] data);
        int k;
        @(posedge clk); #1;
        case (kind)
            0:       begin jdo = mk_load(addr, rd); ta_a = 1'b1; end
            1:       begin jdo = mk_write(data);    ta_b = 1'b1; end
            default: begin jdo = mk_write($urandom()); tna_a = 1'b1; end
        endcase
        k = cyc;
        case (kind)
            0:       m_load(addr, rd, 1'b0, k);
            1:       m_write(data, 1'b0, k);
            default: m_read(1'b0, k);
        endcase
        @(posedge clk); #1; clear_j();
        @(posedge clk); #1;
    endtask

    task automatic avs_wr(input int addr, input logic [31:0] data, input logic [3:0] be);
        @(posedge clk); #1;
        avs_chipselect = 1'b1; avs_write = 1'b1; avs_read = 1'b0;
        avs_address = addr[ADDR_W-1:0]; avs_writedata = data; avs_byteenable = be;
        @(negedge clk);
        check("avs_wr_waitrequest", avs_waitrequest, 1'b0);
        if (addr < DEPTH)
            for (int b = 0; b < 4; b++)
                if (be[b]) m_ram[addr][8*b +: 8] = data[8*b +: 8];
        @(posedge clk); #1; clear_a();
    endtask

    task automatic avs_wait(input int exp_stalls);
        int n;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!avs_waitrequest) break;
            n++;
            @(posedge clk); #1; clear_j();
        end
        check("avs_rd_stalls", n, exp_stalls);
        @(posedge clk); #1; clear_a();
    endtask

    task automatic avs_rd(input int addr);
        @(posedge clk); #1;
        avs_chipselect = 1'b1; avs_read = 1'b1; avs_write = 1'b0;
        avs_address = addr[ADDR_W-1:0];
        aq.push_back(addr < DEPTH ? m_ram[addr] : 32'h0);
        avs_wait(1);
    endtask

    always @(negedge clk) begin
        while (jq.size() > 0 && jq[0].due <= cyc) begin
            e_mon = jq.pop_front();
            if (e_mon.full) begin
                check("monitor_ready", monitor_ready, 1'b1);
                check("MonDReg", MonDReg, e_mon.dreg);
                check("monitor_error", monitor_error, e_mon.err);
            end else begin
                check("ready_cleared", monitor_ready, 1'b0);
            end
        end
        if (avs_chipselect && avs_read && !avs_waitrequest) begin
            if (aq.size() == 0) begin
                checks++; errors++;
                $display("FAIL avs_unexpected_read actual=%h required=none", avs_readdata);
            end else begin
                check("avs_readdata", avs_readdata, aq.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          k;
        int          kind;
        int          addr;
        logic [31:0] d;

        reset_n = 1'b1;
        jdo = '0; clear_j(); clear_a();
        avs_address = '0; avs_writedata = '0; avs_byteenable = '0;
        m_mona = 0; m_dreg = '0; m_err = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_MonDReg", MonDReg, 32'h0);
        check("rst_ready", monitor_ready, 1'b0);
        check("rst_error", monitor_error, 1'b0);
        check("rst_readdata", avs_readdata, 32'h0);
        check("rst_waitrequest", avs_waitrequest, 1'b0);
        @(posedge clk); #1 reset_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) avs_wr(i, $urandom(), 4'hF);

        // Load-and-read, then a plain read proves the load did not increment.
        avs_wr(5, 32'hCAFE0005, 4'hF);
        jtag_op(0, 5, 1'b1, 0);
        check("load_read5", MonDReg, 32'hCAFE0005);
        jtag_op(2, 0, 1'b0, 0);
        check("load_no_incr", MonDReg, 32'hCAFE0005);

        // Burst write and read back
        jtag_op(0, 0, 1'b0, 0);
        jtag_op(1, 0, 1'b0, 32'h11111111);
        jtag_op(1, 0, 1'b0, 32'h22222222);
        jtag_op(1, 0, 1'b0, 32'h33333333);
        jtag_op(0, 0, 1'b0, 0);
        repeat (3) jtag_op(2, 0, 1'b0, 0);
        check("burst_last", MonDReg, 32'h33333333);

        // Range error and clear
        jtag_op(0, 200, 1'b0, 0);
        jtag_op(2, 0, 1'b0, 0);
        check("range_err", monitor_error, 1'b1);
        jtag_op(0, 0, 1'b0, 0);
        check("err_cleared", monitor_error, 1'b0);

        // Address wrap at 2^(ADDR_W+1)
        jtag_op(0, 511, 1'b0, 0);
        jtag_op(1, 0, 1'b0, $urandom());
        jtag_op(2, 0, 1'b0, 0);

        // Byte enables
        avs_wr(33, 32'h0, 4'hF);
        avs_wr(33, 32'hAABBCCDD, 4'b0101);
        jtag_op(0, 33, 1'b1, 0);
        check("byteenable", MonDReg, 32'h00BB00DD);

        // Avalon out of range: writes ignored, reads return zero
        avs_wr(210, 32'h12345678, 4'hF);
        avs_rd(210);

        // Contention: JTAG write to 7 and Avalon read of 7 in the same cycle
        jtag_op(0, 7, 1'b0, 0);
        @(posedge clk); #1;
        d = $urandom();
        jdo = mk_write(d); ta_b = 1'b1;
        avs_chipselect = 1'b1; avs_read = 1'b1; avs_write = 1'b0; avs_address = 8'd7;
        k = cyc;
        m_write(d, 1'b0, k);
        aq.push_back(m_ram[7]);
        avs_wait(2);

        // Deferred read captured in J_RD, then a strobe dropped while pending
        jtag_op(0, 10, 1'b0, 0);
        @(posedge clk); #1;
        jdo = mk_write($urandom()); tna_a = 1'b1;
        k = cyc;
        m_read(1'b0, k);
        @(posedge clk); #1;
        m_read(1'b1, k + 2);
        @(posedge clk); #1;
        tna_a = 1'b0; ta_b = 1'b1; jdo = mk_write(32'hDEADBEEF);
        @(posedge clk); #1; clear_j();
        repeat (3) @(posedge clk);
        #1;
        check("drop_err", monitor_error, 1'b1);
        jtag_op(0, 0, 1'b0, 0);

        // Simultaneous strobes: priority winner executes, losers flag an error
        @(posedge clk); #1;
        jdo = mk_load(20, 1'b1); ta_a = 1'b1; ta_b = 1'b1; tna_a = 1'b1;
        k = cyc;
        m_load(20, 1'b1, 1'b1, k);
        @(posedge clk); #1; clear_j();
        @(posedge clk); #1;
        d = $urandom();
        jdo = mk_write(d); ta_b = 1'b1; tna_a = 1'b1;
        k = cyc;
        m_write(d, 1'b1, k);
        @(posedge clk); #1; clear_j();
        @(posedge clk); #1;

        // Randomized traffic
        for (int i = 0; i < 250; i++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: begin
                    addr = ($urandom_range(0, 3) == 0) ? $urandom_range(190, 511) : $urandom_range(0, DEPTH - 1);
                    jtag_op(0, addr, 1'($urandom_range(0, 1)), 0);
                end
                1: jtag_op(1, 0, 1'b0, $urandom());
                2: jtag_op(2, 0, 1'b0, 0);
                3: avs_wr($urandom_range(0, 255), $urandom(), 4'($urandom_range(0, 15)));
                default: avs_rd($urandom_range(0, 255));
            endcase
        end

        // Reset while in J_RD abandons the read
        jtag_op(0, 40, 1'b0, 0);
        @(posedge clk); #1;
        tna_a = 1'b1;
        @(posedge clk); #1;
        clear_j();
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_mid_MonDReg", MonDReg, 32'h0);
        check("rst_mid_ready", monitor_ready, 1'b0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_after_MonDReg", MonDReg, 32'h0);
        check("rst_after_error", monitor_error, 1'b0);
        m_mona = 0; m_dreg = '0; m_err = 1'b0;
        jtag_op(1, 0, 1'b0, 32'h5A5A0F0F);
        avs_rd(0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("jtag_queue_drained", jq.size(), 0);
        check("avs_queue_drained", aq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nois_system_nios2_qsys_0_ocimem_ctrl.md
# nois_system_nios2_qsys_0_ocimem_ctrl

System-clock debug memory controller sitting directly downstream of the Nios II JTAG debug module wrapper. It decodes the `take_action_ocimem_*` strobes and the `jdo` payload into reads and writes of a single-port on-chip debug RAM, and returns `MonDReg`, `monitor_ready` and `monitor_error` to the wrapper. It also exposes an Avalon-MM slave so the CPU's debug monitor can reach the same RAM. JTAG commands have priority over the CPU port.

## Interface
Parameters:
- `ADDR_W`, 8: word-address width of the RAM and of the Avalon slave; legal range 1..8.
- `DEPTH`, 256: number of implemented 32-bit words; DEPTH ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `jdo`  in  38  command payload from the debug wrapper.
- `take_action_ocimem_a`  in  1  load-address command, one-cycle pulse.
- `take_action_ocimem_b`  in  1  write-and-increment command, one-cycle pulse.
- `take_no_action_ocimem_a`  in  1  read-and-increment command, one-cycle pulse.
- `MonDReg`  out  32  last JTAG read data.
- `monitor_ready`  out  1  last JTAG command completed.
- `monitor_error`  out  1  sticky error flag.
- `avs_address`  in  ADDR_W  CPU word address.
- `avs_chipselect`  in  1  Avalon chip select.
- `avs_read`  in  1  Avalon read request.
- `avs_write`  in  1  Avalon write request.
- `avs_writedata`  in  32  Avalon write data.
- `avs_byteenable`  in  4  Avalon byte lanes.
- `avs_readdata`  out  32  Avalon read data.
- `avs_waitrequest`  out  1  Avalon stall.

## Operation
- **Internal state**
  - `MonAReg`: ADDR_W+1 bits.
  - One-deep JTAG pending register.
  - FSM with states IDLE, J_RD and A_RD.
- **Load address** (`take_action_ocimem_a`)
  - `MonAReg` <= `jdo[ADDR_W+2:2]`.
  - Clears `monitor_error`.
  - If `jdo[35]`=1, a read at the new address follows immediately, with no increment.
  - If `jdo[35]`=0, `monitor_ready` is set next cycle.
- **Write** (`take_action_ocimem_b`)
  - RAM[`MonAReg`] <= `jdo[34:3]`, all four bytes.
  - Then `MonAReg` <= `MonAReg`+1, wrapping modulo 2^(ADDR_W+1).
- **Read** (`take_no_action_ocimem_a`)
  - RAM read at `MonAReg`.
  - `MonDReg` is loaded when the data returns.
  - Then `MonAReg` increments.
- **Range check.** If `MonAReg` ≥ DEPTH on a read or write:
  - no RAM access;
  - `MonDReg` is unchanged;
  - `monitor_error`=1 and `monitor_ready`=1;
  - `MonAReg` still increments.
- **monitor_ready**
  - Cleared in the cycle a JTAG command is accepted.
  - Set when that command completes.
- **FSM transitions**
  - IDLE + JTAG read → J_RD.
  - J_RD → IDLE, with `MonDReg` loaded.
  - IDLE + accepted Avalon read → A_RD.
  - A_RD → IDLE, with `avs_readdata` loaded.
  - Writes complete in IDLE.
- **Arbitration**
  - Avalon is accepted only in IDLE with no JTAG strobe or pending command in the same cycle.
  - A JTAG strobe arriving in J_RD or A_RD is captured in the pending register and executed on the first IDLE cycle.
  - A strobe arriving while a command is already pending is dropped and sets `monitor_error`.
  - Simultaneous JTAG strobes are resolved by priority ocimem_a > ocimem_b > no_action_ocimem_a; the losers are dropped and set `monitor_error`.
- **Avalon byte lanes.** `avs_byteenable[i]` gates byte i of a write. Avalon addresses ≥ DEPTH read 0 and ignore writes, with no error flag.

## Timing
- **Reset values:**
  - `MonDReg`=0, `MonAReg`=0, `avs_readdata`=0;
  - `monitor_ready`=0, `monitor_error`=0;
  - FSM=IDLE, pending register empty;
  - RAM contents undefined.
- **`avs_waitrequest` (combinational)**
  - =1 when chipselect&(read|write) and the request is not completing this cycle; =0 otherwise.
  - Write: completes in the accept cycle, so waitrequest=0 that cycle.
  - Read: waitrequest=1 in the accept cycle; data valid with waitrequest=0 in the next cycle (A_RD).
- **JTAG latencies** (strobe at cycle N, executed immediately):
  - write: RAM updated at the N edge; `monitor_ready`=1 from N+1.
  - read: `MonDReg` and `monitor_ready`=1 from N+2.
  - load address with `jdo[35]`=0: `monitor_ready`=1 from N+1.
  - load address with `jdo[35]`=1: behaves as a read, ready from N+2.
- **Deferred command.** A pending JTAG command adds at most 1 cycle; it blocks Avalon for its duration.
- **Reset mid-operation.** Asserting `reset_n` in J_RD or A_RD abandons the read: no `MonDReg` or `avs_readdata` update, and the pending register is cleared.

## Test plan
- **Load and read:** load address 5 (`jdo[6:2]`=5, `jdo[35]`=1) after RAM[5] was written as 32'hCAFE0005 → `MonDReg`=32'hCAFE0005 at N+2, `monitor_ready`=1, `MonAReg`=5.
- **Burst write then read back:** three ocimem_b writes of 32'h11111111, 32'h22222222, 32'h33333333 from address 0, reload 0, three reads → same values in order; `MonAReg` ends at 3.
- **Range error:** DEPTH=200, load 200 then read → `monitor_error`=1, `monitor_ready`=1, `MonDReg` unchanged, `MonAReg`=201; the next load clears the error.
- **Contention:** Avalon read to address 7 asserted in the same cycle as a JTAG write → JTAG write wins, `avs_waitrequest`=1; the Avalon read completes two cycles later with the correct data.
- **Byte enables:** Avalon write of 32'hAABBCCDD with byteenable 4'b0101 over 32'h0 → subsequent JTAG read returns 32'h00BB00DD.
- **Reset mid-read:** `reset_n` pulsed low in J_RD → `MonDReg`=0, `monitor_ready`=0, FSM IDLE after release.
